// File: rtl/input_sequencer.sv
// Debounced switch-entry sequencer: SW[1] strobes in SW[0] as one bit per press.
// Ports: clk, rst (sync, active-high), SW[1:0] raw; bit_valid/bit_value, history[15:0],
// count[4:0] (saturates at 16), clear_pulse, busy.
// Optional long-hold history clear is enabled by defining INPUT_SEQ_CLEAR_EN.
module input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CLEAR_CYCLES    = 200000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  SW,
  output logic        bit_valid,
  output logic        bit_value,
  output logic [15:0] history,
  output logic [4:0]  count,
  output logic        clear_pulse,
  output logic        busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARM     = 3'd1;
  localparam logic [2:0] ISSUE   = 3'd2;
  localparam logic [2:0] HELD    = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  logic [1:0]    sync1;
  logic [1:0]    sync0;
  logic          sw1_s;
  logic          sw0_s;
  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_n;
  logic          clear_fire;

  assign sw1_s = sync1[1];
  assign sw0_s = sync0[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 2'b00;
      sync0 <= 2'b00;
    end else begin
      sync1 <= {sync1[0], SW[1]};
      sync0 <= {sync0[0], SW[0]};
    end
  end

  // Debounce counter is shared by ARM (press) and RELEASE (release).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (sw1_s) begin
          state_n = ARM;
          cnt_n   = DW'(1);
        end
      end
      ARM: begin
        if (!sw1_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DB_MAX) begin
          state_n = ISSUE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ISSUE: begin
        state_n = HELD;
      end
      HELD: begin
        if (!sw1_s) begin
          state_n = RELEASE;
          cnt_n   = DW'(1);
        end
      end
      RELEASE: begin
        if (sw1_s) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == DB_MAX) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef INPUT_SEQ_CLEAR_EN
  localparam int HW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [HW-1:0] CL_MAX  = HW'(CLEAR_CYCLES);
  localparam logic [HW-1:0] CL_TRIG = HW'(CLEAR_CYCLES - 1);

  logic [HW-1:0] hold;

  // Hold time counts HELD cycles since ISSUE; it saturates so a
  // single hold can clear at most once.
  assign clear_fire = (state == HELD) && (state_n == HELD) &&
                      (hold == CL_TRIG);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      clear_pulse <= 1'b0;
    end else begin
      clear_pulse <= clear_fire;
      if (state == ISSUE) begin
        hold <= HW'(1);
      end else if (state == HELD && state_n == HELD && hold != CL_MAX) begin
        hold <= hold + 1'b1;
      end
    end
  end
`else
  assign clear_fire  = 1'b0;
  assign clear_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      bit_valid <= 1'b0;
      bit_value <= 1'b0;
      history   <= 16'h0000;
      count     <= 5'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      busy      <= (state_n != IDLE);
      bit_valid <= (state_n == ISSUE);
      if (state == ARM && state_n == ISSUE) begin
        bit_value <= sw0_s;
      end
      // Shift happens on the edge that ends ISSUE, so a reset
      // during ISSUE suppresses it.
      if (state == ISSUE) begin
        history <= {history[14:0], bit_value};
        if (count != 5'd16) begin
          count <= count + 5'd1;
        end
      end
      if (clear_fire) begin
        history <= 16'h0000;
        count   <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_input_sequencer.sv
// Self-checking bench for input_sequencer (DEBOUNCE_CYCLES=4, CLEAR_CYCLES=10).
// Random press/glitch stimulus compared against a queue-of-accepted-bits model.
module tb_input_sequencer;

  localparam int D = 4;
  localparam int C = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  SW = 2'b00;
  logic        bit_valid;
  logic        bit_value;
  logic [15:0] history;
  logic [4:0]  count;
  logic        clear_pulse;
  logic        busy;

  int nchecks = 0;
  int nfail   = 0;

  int   cyc;
  int   pulses;
  int   first_at;
  logic last_vb;
  int   clears;
  int   clear_at;
  logic [15:0] hist_at_clear;
  logic [4:0]  cnt_at_clear;

  bit q[$];

  input_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .CLEAR_CYCLES(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SW(SW),
    .bit_valid(bit_valid),
    .bit_value(bit_value),
    .history(history),
    .count(count),
    .clear_pulse(clear_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_hist();
    logic [15:0] h;
    h = 16'h0000;
    foreach (q[i]) h = {h[14:0], q[i]};
    return h;
  endfunction

  function automatic logic [4:0] model_count();
    return (q.size() > 16) ? 5'd16 : 5'(q.size());
  endfunction

  task automatic clr_mon();
    cyc      = 0;
    pulses   = 0;
    first_at = -1;
    clears   = 0;
    clear_at = -1;
  endtask

  // Drive SW for n cycles, sampling outputs 1ns after each rising edge.
  task automatic run(input logic s1, input logic s0, input int n);
    for (int i = 0; i < n; i++) begin
      SW = {s1, s0};
      @(posedge clk);
      #1;
      cyc++;
      if (bit_valid) begin
        pulses++;
        if (first_at < 0) first_at = cyc;
        last_vb = bit_value;
      end
      if (clear_pulse) begin
        clears++;
        if (clear_at < 0) clear_at = cyc;
        hist_at_clear = history;
        cnt_at_clear  = count;
      end
    end
  endtask

  // A press of hi cycles then lo cycles low; SW[0] scrambles after capture.
  task automatic press(input bit b, input int hi, input int lo);
    for (int i = 0; i < hi + lo; i++) begin
      run(i < hi, (i < 8) ? b : 1'($urandom), 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    SW  = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    nchecks++;
    if (bit_valid !== 1'b0 || bit_value !== 1'b0 || busy !== 1'b0 ||
        clear_pulse !== 1'b0) begin
      nfail++;
      $display("FAIL reset_flags: got valid=%b value=%b busy=%b clr=%b want 0",
               bit_valid, bit_value, busy, clear_pulse);
    end
    nchecks++;
    if (history !== 16'h0000 || count !== 5'd0) begin
      nfail++;
      $display("FAIL reset_regs: got history=%h count=%0d want 0000/0",
               history, count);
    end
  endtask

  task automatic test_single_press();
    do_reset();
    clr_mon();
    run(1'b1, 1'b1, 5);
    nchecks++;
    if (busy !== 1'b1) begin
      nfail++;
      $display("FAIL busy_during_press: got %b want 1", busy);
    end
    run(1'b1, 1'b1, 7);
    run(1'b0, 1'b1, 12);
    q.push_back(1'b1);
    nchecks++;
    if (pulses !== 1 || first_at !== D + 3) begin
      nfail++;
      $display("FAIL single_latency: got pulses=%0d at=%0d want 1 at %0d",
               pulses, first_at, D + 3);
    end
    nchecks++;
    if (last_vb !== 1'b1 || history !== 16'h0001 || count !== 5'd1) begin
      nfail++;
      $display("FAIL single_state: got bit=%b hist=%h cnt=%0d want 1/0001/1",
               last_vb, history, count);
    end
    nchecks++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("FAIL single_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_glitch();
    logic [15:0] h0;
    h0 = history;
    clr_mon();
    press(1'b0, 3, 10);
    nchecks++;
    if (pulses !== 0 || busy !== 1'b0 || history !== h0) begin
      nfail++;
      $display("FAIL glitch3: got pulses=%0d busy=%b hist=%h want 0/0/%h",
               pulses, busy, history, h0);
    end
    clr_mon();
    press(1'b0, D, 10);
    nchecks++;
    if (pulses !== 0 || history !== h0) begin
      nfail++;
      $display("FAIL glitch_edge: got pulses=%0d hist=%h want 0/%h",
               pulses, history, h0);
    end
    clr_mon();
    press(1'b0, D + 1, 12);
    q.push_back(1'b0);
    nchecks++;
    if (pulses !== 1 || first_at !== D + 3 || history !== model_hist()) begin
      nfail++;
      $display("FAIL min_press: got pulses=%0d at=%0d hist=%h want 1/%0d/%h",
               pulses, first_at, history, D + 3, model_hist());
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      press((i % 2) == 0, 8, 10);
      q.push_back((i % 2) == 0);
    end
    nchecks++;
    if (count !== 5'd16 || history !== 16'h5555) begin
      nfail++;
      $display("FAIL saturate: got cnt=%0d hist=%h want 16/5555",
               count, history);
    end
    press(1'b0, 8, 10);
    q.push_back(1'b0);
    nchecks++;
    if (count !== 5'd16 || history !== model_hist()) begin
      nfail++;
      $display("FAIL saturate_hold: got cnt=%0d hist=%h want 16/%h",
               count, history, model_hist());
    end
  endtask

  task automatic test_random();
    int  hi;
    int  lo;
    bit  b;
    int  exp_p;
    for (int n = 0; n < 24; n++) begin
      b  = 1'($urandom);
      hi = ($urandom_range(0, 2) == 0) ? $urandom_range(1, D)
                                       : $urandom_range(D + 1, 12);
      lo = $urandom_range(9, 15);
      clr_mon();
      press(b, hi, lo);
      exp_p = (hi >= D + 1) ? 1 : 0;
      if (exp_p == 1) q.push_back(b);
      nchecks++;
      if (pulses !== exp_p || (exp_p == 1 && last_vb !== b)) begin
        nfail++;
        $display("FAIL rand_pulse[%0d]: got pulses=%0d bit=%b want %0d/%b hi=%0d",
                 n, pulses, last_vb, exp_p, b, hi);
      end
      nchecks++;
      if (history !== model_hist() || count !== model_count()) begin
        nfail++;
        $display("FAIL rand_state[%0d]: got hist=%h cnt=%0d want %h/%0d",
                 n, history, count, model_hist(), model_count());
      end
    end
  endtask

  task automatic test_release_bounce();
    clr_mon();
    run(1'b1, 1'b1, 8);
    run(1'b0, 1'b1, 2);
    run(1'b1, 1'b1, 1);
    run(1'b0, 1'b1, 3);
    run(1'b1, 1'b0, 5);
    run(1'b0, 1'b0, 12);
    q.push_back(1'b1);
    nchecks++;
    if (pulses !== 1 || last_vb !== 1'b1) begin
      nfail++;
      $display("FAIL bounce: got pulses=%0d bit=%b want 1/1", pulses, last_vb);
    end
    clr_mon();
    run(1'b1, 1'b0, 8);
    run(1'b0, 1'b0, D);
    run(1'b1, 1'b1, 5);
    run(1'b0, 1'b1, 12);
    q.push_back(1'b0);
    nchecks++;
    if (pulses !== 1 || history !== model_hist()) begin
      nfail++;
      $display("FAIL short_release: got pulses=%0d hist=%h want 1/%h",
               pulses, history, model_hist());
    end
    clr_mon();
    run(1'b1, 1'b1, 8);
    run(1'b0, 1'b1, D + 1);
    run(1'b1, 1'b0, 8);
    run(1'b0, 1'b0, 12);
    q.push_back(1'b1);
    q.push_back(1'b0);
    nchecks++;
    if (pulses !== 2 || last_vb !== 1'b0 || history !== model_hist()) begin
      nfail++;
      $display("FAIL full_release: got pulses=%0d bit=%b hist=%h want 2/0/%h",
               pulses, last_vb, history, model_hist());
    end
  endtask

  task automatic test_reset_in_issue();
    int  k;
    bit  seen;
    press(1'b1, 8, 10);
    q.push_back(1'b1);
    seen = 0;
    k    = 0;
    SW   = 2'b11;
    while (!seen && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (bit_valid) seen = 1;
    end
    nchecks++;
    if (!seen || k !== D + 3) begin
      nfail++;
      $display("FAIL issue_reach: got seen=%0d at=%0d want 1 at %0d",
               seen, k, D + 3);
    end
    rst = 1'b1;
    SW  = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    nchecks++;
    if (bit_valid !== 1'b0 || history !== 16'h0000 || count !== 5'd0 ||
        busy !== 1'b0) begin
      nfail++;
      $display("FAIL rst_issue: got v=%b hist=%h cnt=%0d busy=%b want 0/0000/0/0",
               bit_valid, history, count, busy);
    end
    clr_mon();
    run(1'b0, 1'b0, 10);
    nchecks++;
    if (pulses !== 0 || history !== 16'h0000 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL rst_issue_after: got pulses=%0d hist=%h busy=%b want 0/0/0",
               pulses, history, busy);
    end
  endtask

  task automatic test_clear();
    do_reset();
    press(1'b0, 8, 10);
    q.push_back(1'b0);
    clr_mon();
    run(1'b1, 1'b1, 30);
    run(1'b0, 1'b1, 12);
    q.push_back(1'b1);
`ifdef INPUT_SEQ_CLEAR_EN
    q.delete();
    nchecks++;
    if (clears !== 1 || clear_at !== D + 3 + C) begin
      nfail++;
      $display("FAIL clear_pulse: got clears=%0d at=%0d want 1 at %0d",
               clears, clear_at, D + 3 + C);
    end
    nchecks++;
    if (hist_at_clear !== 16'h0000 || cnt_at_clear !== 5'd0) begin
      nfail++;
      $display("FAIL clear_state: got hist=%h cnt=%0d want 0000/0",
               hist_at_clear, cnt_at_clear);
    end
`else
    nchecks++;
    if (clears !== 0) begin
      nfail++;
      $display("FAIL clear_off: got clears=%0d want 0", clears);
    end
`endif
    nchecks++;
    if (pulses !== 1 || history !== model_hist() || count !== model_count()) begin
      nfail++;
      $display("FAIL long_hold: got pulses=%0d hist=%h cnt=%0d want 1/%h/%0d",
               pulses, history, count, model_hist(), model_count());
    end
  endtask

  initial begin
    last_vb       = 1'b0;
    hist_at_clear = 16'h0000;
    cnt_at_clear  = 5'd0;
    clr_mon();
    test_reset();
    test_single_press();
    test_glitch();
    test_saturate();
    test_random();
    test_release_bounce();
    test_reset_in_issue();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/input_sequencer.md
INPUT_SEQUENCER -- requirements
Module: input_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the consecutive stable cycles needed to accept an SW[1] level change (minimum 2).
REQ-002 Parameter CLEAR_CYCLES, default 200000000, SHALL set the SW[1] hold time, counted from issue, that triggers a history clear (used only with INPUT_SEQ_CLEAR_EN).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SW  input  2  raw asynchronous switches; SW[1] is the enter strobe, SW[0] is the data bit.
REQ-006 bit_valid  output  1  one-cycle pulse marking an accepted bit for the downstream recogniser.
REQ-007 bit_value  output  1  accepted bit; held stable from the bit_valid cycle until the next bit_valid.
REQ-008 history  output  16  last 16 accepted bits for the display driver; newest bit in history[0].
REQ-009 count  output  5  number of accepted bits since reset or clear; saturates at 16.
REQ-010 clear_pulse  output  1  one-cycle pulse requesting a downstream reset; used only with INPUT_SEQ_CLEAR_EN.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Each SW bit SHALL pass through a 2-flop synchronizer; all logic below uses only the synchronized copies sw1_s and sw0_s.
REQ-013 The FSM SHALL have states IDLE, ARM, ISSUE, HELD and RELEASE, with registered outputs.
REQ-014 IDLE: sw1_s=1 -> ARM, debounce counter loaded to 1.
REQ-015 ARM: sw1_s=0 -> IDLE (glitch rejected, no bit issued); counter reaches DEBOUNCE_CYCLES -> ISSUE, capturing sw0_s into bit_value.
REQ-016 ISSUE: lasts exactly one cycle with bit_valid=1; history <= {history[14:0], bit_value}; count <= min(count+1, 16); next state HELD.
REQ-017 HELD: sw1_s=0 -> RELEASE, counter loaded to 1; otherwise remain in HELD, with no further bits issued regardless of SW[0] activity.
REQ-018 RELEASE: sw1_s=1 -> HELD (glitch rejected); counter reaches DEBOUNCE_CYCLES -> IDLE.
REQ-019 Latency: bit_valid SHALL assert exactly DEBOUNCE_CYCLES+3 cycles after SW[1] rises and is held stable.
REQ-020 At most one bit_valid per debounced press/release cycle; a re-press is ignored until RELEASE completes.
REQ-021 history SHALL discard history[15] on every shift; count SHALL stay at 16 once reached, with no wrap.
REQ-022 bit_value SHALL reflect SW[0] as sampled at the ARM->ISSUE transition; later SW[0] changes are ignored until the next press.

Reset
REQ-023 rst SHALL force state IDLE, all counters to 0, bit_valid=0, bit_value=0, history=16'h0000, count=0, clear_pulse=0, busy=0 and synchronizer flops to 0 on the next edge.
REQ-024 rst asserted in any state, including ISSUE, SHALL suppress that cycle's shift and pulse; rst has priority over all other events.

Configuration
REQ-025 Macro INPUT_SEQ_CLEAR_EN defined: a hold counter SHALL run in HELD from the ISSUE cycle.
REQ-026 When that counter reaches CLEAR_CYCLES, clear_pulse SHALL pulse for one cycle, history=0 and count=0 in the same cycle; the FSM stays in HELD, the held bit is discarded, and at most one clear occurs per hold.
REQ-027 Macro INPUT_SEQ_CLEAR_EN undefined: clear_pulse SHALL be tied to 0, there is no hold counter, and long holds have no effect.

Verification (DEBOUNCE_CYCLES=4, CLEAR_CYCLES=10)
REQ-028 Reset, then SW=2'b11 held -> bit_valid exactly once, 7 cycles after the SW change; bit_value=1, history=16'h0001, count=1.
REQ-029 SW[1] high for 3 cycles then low -> no bit_valid; busy returns to 0; history unchanged.
REQ-030 17 clean presses with bits 1,0,1,0,... -> count=16 (saturated), history=16'h5555; newest bit, value 1, in history[0].
REQ-031 SW[1] bounce of 1 low cycle during RELEASE, then re-press -> no second bit_valid until 4 stable low cycles complete.
REQ-032 rst asserted in the ISSUE cycle -> bit_valid=0, history=0, count=0, and the state is IDLE on the next cycle.
REQ-033 With INPUT_SEQ_CLEAR_EN defined, SW[1] held for 12 cycles after issue -> one clear_pulse, 10 cycles after ISSUE; history=0, count=0. Without the macro -> clear_pulse stays 0.
